// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioner.
//   N_DEFAULT / TICK_DIV_DEFAULT / SAMPLES_DEFAULT : default parameter values
//   TICK_DIV_MIN/MAX, SAMPLES_MIN/MAX              : legal parameter ranges
//   level_t                                        : debounced button level
//   cnt_width()                                    : prescaler counter width
package button_pkg;

  localparam int unsigned N_DEFAULT        = 21;
  localparam int unsigned TICK_DIV_DEFAULT = 12000;
  localparam int unsigned TICK_DIV_MIN     = 1;
  localparam int unsigned TICK_DIV_MAX     = 1 << 24;
  localparam int unsigned SAMPLES_DEFAULT  = 4;
  localparam int unsigned SAMPLES_MIN      = 2;
  localparam int unsigned SAMPLES_MAX      = 8;

  typedef enum logic {
    LEVEL_RELEASED = 1'b0,
    LEVEL_PRESSED  = 1'b1
  } level_t;

  // At least one bit so TICK_DIV of 1 or 2 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchronizer, SAMPLES-deep tick-sampled history,
// debounced level and registered edge strobes.
//   clk, reset : system clock, asynchronous active-high reset
//   tick       : shared sample strobe from the prescaler
//   raw        : asynchronous button level, 1 = pressed
//   clean      : debounced level
//   rise, fall : one-cycle strobes on debounced 0->1 / 1->0
module debounce_cell
  import button_pkg::*;
#(
  parameter int unsigned SAMPLES = SAMPLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  logic               meta;
  logic               sync;
  logic [SAMPLES-1:0] hist;
  logic [SAMPLES-1:0] hist_next;
  level_t             state;
  level_t             state_next;
  logic               rise_next;
  logic               fall_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      state <= LEVEL_RELEASED;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      hist  <= hist_next;
      state <= state_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Decision uses the history including this tick's sample, so the level
  // flips on the very tick that completes SAMPLES agreeing samples.
  always_comb begin
    hist_next  = hist;
    state_next = state;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (tick) begin
      hist_next = {hist[SAMPLES-2:0], sync};
      case (state)
        LEVEL_RELEASED: begin
          if (&hist_next) begin
            state_next = LEVEL_PRESSED;
            rise_next  = 1'b1;
          end
        end
        LEVEL_PRESSED: begin
          if (~|hist_next) begin
            state_next = LEVEL_RELEASED;
            fall_next  = 1'b1;
          end
        end
        default: state_next = LEVEL_RELEASED;
      endcase
    end
  end

  assign clean = (state == LEVEL_PRESSED);

endmodule

// File: rtl/button_conditioner.sv
// Debounces N push buttons with a shared sample-tick prescaler.
//   clk, reset : system clock, asynchronous active-high reset
//   pb_raw     : raw asynchronous button levels, 1 = pressed
//   pb_clean   : debounced levels (registered)
//   pb_rise    : one-cycle strobe per debounced 0->1 (registered)
//   pb_fall    : one-cycle strobe per debounced 1->0 (registered)
//   any_press  : combinational OR of pb_rise
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned SAMPLES  = SAMPLES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pb_raw,
  output logic [N-1:0] pb_clean,
  output logic [N-1:0] pb_rise,
  output logic [N-1:0] pb_fall,
  output logic         any_press
);

  localparam int unsigned      CNT_W    = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    debounce_cell #(
      .SAMPLES(SAMPLES)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (pb_raw[i]),
      .clean(pb_clean[i]),
      .rise (pb_rise[i]),
      .fall (pb_fall[i])
    );
  end

  assign any_press = |pb_rise;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (N=21, TICK_DIV=4, SAMPLES=3).
// Reference model: per-bit run lengths of agreeing tick samples, where the
// sample seen on edge e is the raw level present two edges earlier.
module tb_button_conditioner;

  localparam int N = 21;
  localparam int T = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] pb_raw = '0;
  logic [N-1:0] pb_clean;
  logic [N-1:0] pb_rise;
  logic [N-1:0] pb_fall;
  logic         any_press;

  button_conditioner #(
    .N       (N),
    .TICK_DIV(T),
    .SAMPLES (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pb_raw   (pb_raw),
    .pb_clean (pb_clean),
    .pb_rise  (pb_rise),
    .pb_fall  (pb_fall),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           edges;
  logic [N-1:0] raw_log[$];
  int           ones[N];
  int           zeros[N];
  logic [N-1:0] m_clean;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;

  task automatic model_clear();
    edges = 0;
    raw_log.delete();
    for (int i = 0; i < N; i++) begin
      ones[i]  = 0;
      zeros[i] = 0;
    end
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] smp;
    if (reset) begin
      model_clear();
    end else begin
      edges++;
      m_rise = '0;
      m_fall = '0;
      smp = (raw_log.size() >= 2) ? raw_log[raw_log.size()-2] : '0;
      raw_log.push_back(pb_raw);
      if (raw_log.size() > 4) void'(raw_log.pop_front());
      if (edges % T == 0) begin
        for (int i = 0; i < N; i++) begin
          if (smp[i]) begin
            ones[i]  = (ones[i] < S) ? ones[i] + 1 : S;
            zeros[i] = 0;
          end else begin
            zeros[i] = (zeros[i] < S) ? zeros[i] + 1 : S;
            ones[i]  = 0;
          end
          if (!m_clean[i] && ones[i] >= S) begin
            m_clean[i] = 1'b1;
            m_rise[i]  = 1'b1;
          end else if (m_clean[i] && zeros[i] >= S) begin
            m_clean[i] = 1'b0;
            m_fall[i]  = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- stepping and comparison ----------------
  int rise_cnt[N];
  int fall_cnt[N];

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic compare();
    check("clean", 32'(pb_clean), 32'(m_clean));
    check("rise", 32'(pb_rise), 32'(m_rise));
    check("fall", 32'(pb_fall), 32'(m_fall));
    check("any_press", 32'(any_press), 32'(|m_rise));
    check("rise_and_fall", 32'(pb_rise & pb_fall), 32'(0));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare();
      for (int i = 0; i < N; i++) begin
        if (pb_rise[i]) rise_cnt[i]++;
        if (pb_fall[i]) fall_cnt[i]++;
      end
    end
  endtask

  int lat;
  int lat_b;
  int total;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    clear_counts();
    reset = 1'b1;
    #1;
    compare();
    step(2);
    reset = 1'b0;

    // idle: no strobes
    step(100);
    total = 0;
    for (int i = 0; i < N; i++) total += rise_cnt[i] + fall_cnt[i];
    check("idle_strobes", 32'(total), 32'(0));

    // single press, long hold
    clear_counts();
    pb_raw[0] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      if (pb_rise[0] && lat < 0) lat = k;
    end
    check("press_latency_in_range", 32'(lat >= 2 && lat <= 15), 32'(1));
    check("press_rise_once", 32'(rise_cnt[0]), 32'(1));
    check("press_clean_held", 32'(pb_clean[0]), 32'(1));
    pb_raw[0] = 1'b0;
    step(30);
    check("release_fall_once", 32'(fall_cnt[0]), 32'(1));

    // short glitches on bit 5
    clear_counts();
    for (int k = 0; k < 200; k++) begin
      pb_raw[5] = (k % 8 == 0);
      step(1);
      check("glitch_clean", 32'(pb_clean[5]), 32'(0));
    end
    pb_raw[5] = 1'b0;
    check("glitch_strobes", 32'(rise_cnt[5] + fall_cnt[5]), 32'(0));
    step(20);

    // simultaneous bits 0 and 20
    clear_counts();
    pb_raw[0]  = 1'b1;
    pb_raw[20] = 1'b1;
    lat = -1;
    lat_b = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (pb_rise[0] && lat < 0) lat = k;
      if (pb_rise[20] && lat_b < 0) lat_b = k;
    end
    check("simul_rise_seen", 32'(lat > 0), 32'(1));
    check("simul_rise_same", 32'(lat_b), 32'(lat));
    pb_raw[0]  = 1'b0;
    pb_raw[20] = 1'b0;
    lat = -1;
    lat_b = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (pb_fall[0] && lat < 0) lat = k;
      if (pb_fall[20] && lat_b < 0) lat_b = k;
    end
    check("simul_fall_seen", 32'(lat > 0), 32'(1));
    check("simul_fall_same", 32'(lat_b), 32'(lat));

    // reset mid-qualification
    clear_counts();
    pb_raw[3] = 1'b1;
    step(5);
    reset = 1'b1;
    #1;
    model_clear();
    compare();
    step(2);
    reset = 1'b0;
    clear_counts();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (pb_rise[3] && lat < 0) lat = k;
    end
    check("post_reset_latency", 32'(lat >= 2 && lat <= 15), 32'(1));
    check("post_reset_rise_once", 32'(rise_cnt[3]), 32'(1));
    pb_raw[3] = 1'b0;
    step(20);

    // random activity with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) pb_raw[i] = ~pb_raw[i];
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N, default 21: number of push-button inputs conditioned.
REQ-002 Parameter TICK_DIV, default 12000: clock cycles per debounce sample tick (1 ms at 12 MHz).
REQ-003 Parameter SAMPLES, default 4: consecutive agreeing samples required to change a debounced level; legal range 2..8.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pb_raw  input  N  raw asynchronous push-button levels, 1 = pressed.
REQ-007 pb_clean  output  N  debounced button levels.
REQ-008 pb_rise  output  N  one-cycle strobe per bit on a debounced 0->1 transition.
REQ-009 pb_fall  output  N  one-cycle strobe per bit on a debounced 1->0 transition.
REQ-010 any_press  output  1  OR of all pb_rise bits, same cycle.

Function
REQ-011 Each pb_raw bit SHALL pass through a 2-flop synchronizer before any other use; no logic SHALL sample pb_raw directly.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, asserting an internal tick in the cycle the count equals TICK_DIV-1.
REQ-013 Per bit, on each tick edge the synchronized level SHALL shift into a SAMPLES-deep history register; no shift occurs on non-tick cycles.
REQ-014 On a tick edge where the updated history is all ones and pb_clean is 0, pb_clean SHALL become 1 and pb_rise SHALL become 1.
REQ-015 On a tick edge where the updated history is all zeros and pb_clean is 1, pb_clean SHALL become 0 and pb_fall SHALL become 1.
REQ-016 pb_rise and pb_fall SHALL be 0 on every other edge: exactly one cycle wide, never both high for a bit.
REQ-017 Mixed history SHALL hold pb_clean unchanged; glitches shorter than SAMPLES consecutive ticks SHALL produce no strobe.
REQ-018 Press-to-pb_rise latency for a clean step SHALL be at most 2 + SAMPLES*TICK_DIV + 1 cycles and at least 2 + (SAMPLES-1)*TICK_DIV cycles.
REQ-019 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL strobe in the same cycle.
REQ-020 any_press SHALL be combinational OR of pb_rise; no extra latency.
REQ-021 A button held indefinitely SHALL produce exactly one pb_rise and no further strobes until release.

Reset
REQ-022 Reset assertion SHALL immediately clear synchronizers, prescaler, all histories, pb_clean, pb_rise, pb_fall, any_press to 0, regardless of clock.
REQ-023 A button held through reset deassertion SHALL produce a pb_rise after qualification (REQ-018 timing measured from deassertion).
REQ-024 Reset mid-qualification SHALL discard partial history; no strobe from pre-reset samples.

Structure
REQ-025 Default parameter values, TICK_DIV range limits and N SHALL live in shared package button_pkg.
REQ-026 Per-bit synchronizer, history and strobe logic SHALL be sub-module debounce_cell, instantiated N times by generate; prescaler remains in button_conditioner.
REQ-027 Outputs SHALL be registered (except any_press); pb_clean and strobes feed the key encoder directly.

Verification (N=21, TICK_DIV=4, SAMPLES=3)
REQ-028 Reset, pb_raw=0 for 100 cycles -> all outputs 0, no strobes.
REQ-029 pb_raw[0] 0->1 held -> one pb_rise[0] and any_press pulse within 2..15 cycles, pb_clean[0]=1 thereafter, no repeat strobe over 200 cycles.
REQ-030 pb_raw[5] toggles 1 cycle high every 8 cycles (glitch < 3 ticks agreement) -> pb_clean[5] stays 0, no strobes.
REQ-031 pb_raw[0] and pb_raw[20] rise same cycle -> pb_rise[0] and pb_rise[20] same cycle; release both -> pb_fall on both same cycle.
REQ-032 pb_raw[3] held, reset pulsed mid-qualification (after 1 tick) -> outputs 0 during reset; after release pb_rise[3] once, within 15 cycles of deassertion.
REQ-033 Every test -> assertion: pb_rise & pb_fall == 0 each cycle, each strobe exactly one cycle wide.
